// File: rtl/tx_shift_ctrl_if.sv
// Upstream byte handshake between a byte source and the transmit shift sequencer.
interface tx_shift_ctrl_if;
    logic byte_valid;
    logic byte_last;
    logic byte_ready;

    modport master (
        output byte_valid,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_last,
        output byte_ready
    );
endinterface

// File: rtl/tx_shift_ctrl.sv
// Sequencer for a transmit PISO shifter: accepts bytes over a valid/ready
// handshake and issues load/shift/clear so each bit sits on the serial line
// for CLKS_PER_BIT clocks, MSB first, streaming bytes back-to-back per frame.
//
// state | meaning
// IDLE  | waiting for tx_en and a byte offer; byte_ready follows tx_en
// SHIFT | holding a bit; timer paces the bit, bit_cnt indexes it
// DONE  | one-cycle frame teardown: shifter cleared, frame_done/underrun closed
module tx_shift_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              tx_en,
    input  logic              abort,
    tx_shift_ctrl_if.slave    up,
    output logic              shreg_load,
    output logic              shreg_shift,
    output logic              shreg_clear,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
    logic            last_q, last_nxt;
    // remembers that DONE was entered through an underrun, suppressing frame_done
    logic            ur_q, ur_nxt;

    logic            ready_c;
    logic            accept;
    logic            t_term;
    logic            b_term;

    assign t_term        = (timer == T_LAST);
    assign b_term        = (bit_cnt == B_LAST);
    assign accept        = up.byte_valid & ready_c;
    assign up.byte_ready = ready_c;
    assign shreg_load    = accept;
    assign busy          = (state != S_IDLE);

    // State and counter register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            last_q  <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_cnt <= bit_cnt_nxt;
            last_q  <= last_nxt;
            ur_q    <= ur_nxt;
        end
    end

    // Next-state and next-counter logic; abort pre-empts everything outside IDLE.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_cnt_nxt = bit_cnt;
        last_nxt    = last_q;
        ur_nxt      = ur_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt   = S_SHIFT;
                    timer_nxt   = '0;
                    bit_cnt_nxt = '0;
                    last_nxt    = up.byte_last;
                    ur_nxt      = 1'b0;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_nxt   = S_IDLE;
                    timer_nxt   = '0;
                    bit_cnt_nxt = '0;
                    last_nxt    = 1'b0;
                    ur_nxt      = 1'b0;
                end else if (accept) begin
                    // back-to-back reload at the byte boundary
                    timer_nxt   = '0;
                    bit_cnt_nxt = '0;
                    last_nxt    = up.byte_last;
                    ur_nxt      = 1'b0;
                end else if (t_term) begin
                    if (!b_term) begin
                        timer_nxt   = '0;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end else begin
                        // a non-last byte with no follower is an underrun
                        state_nxt = S_DONE;
                        ur_nxt    = ~last_q;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt   = S_IDLE;
                timer_nxt   = '0;
                bit_cnt_nxt = '0;
                last_nxt    = 1'b0;
                ur_nxt      = 1'b0;
            end
            default: begin
                state_nxt   = S_IDLE;
                timer_nxt   = '0;
                bit_cnt_nxt = '0;
                last_nxt    = 1'b0;
                ur_nxt      = 1'b0;
            end
        endcase
    end

    // Output decode: handshake ready, shifter strobes and frame status pulses.
    always_comb begin
        ready_c     = 1'b0;
        shreg_shift = 1'b0;
        shreg_clear = 1'b0;
        frame_done  = 1'b0;
        underrun    = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = tx_en & ~abort;
            end
            S_SHIFT: begin
                if (abort) begin
                    shreg_clear = 1'b1;
                end else if (t_term) begin
                    if (!b_term) begin
                        shreg_shift = 1'b1;
                    end else if (!last_q) begin
                        ready_c  = 1'b1;
                        underrun = ~up.byte_valid;
                    end
                end
            end
            S_DONE: begin
                shreg_clear = 1'b1;
                frame_done  = ~abort & ~ur_q;
            end
            default: begin
                shreg_clear = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_tx_shift_ctrl.sv
// Scoreboard bench for tx_shift_ctrl with a behavioural shifter on its strobes.
// The driver pushes the expected serial stream and frame-end kind on every
// accepted byte; a negedge monitor pops and compares as the DUT produces them.
module tb_tx_shift_ctrl;
    localparam int DB  = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic tx_en = 1'b0;
    logic abort = 1'b0;
    logic shreg_load, shreg_shift, shreg_clear, busy, frame_done, underrun;

    tx_shift_ctrl_if bus();

    tx_shift_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .tx_en       (tx_en),
        .abort       (abort),
        .up          (bus),
        .shreg_load  (shreg_load),
        .shreg_shift (shreg_shift),
        .shreg_clear (shreg_clear),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // behavioural PISO shifter driven by the controller strobes
    logic [DB-1:0] sreg;
    logic [DB-1:0] cur_data;
    logic          serial_out;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)           sreg <= '0;
        else if (shreg_clear) sreg <= '0;
        else if (shreg_load)  sreg <= cur_data;
        else if (shreg_shift) sreg <= {sreg[DB-2:0], 1'b0};
    end
    assign serial_out = sreg[DB-1];

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_serial [$];
    int end_q [$];          // 1 = frame_done expected, 2 = underrun expected
    int pending = 0;
    int cyc = 0;
    int last_pop = -10;
    bit post_abort = 0;
    logic [7:0] fb [0:3];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: compares each produced serial bit and frame-end pulse against the queues
    always @(negedge clk) begin
        cyc++;
        if (!n_rst) begin
            pending    = 0;
            post_abort = 0;
        end else begin
            check("strobe_exclusive", int'(shreg_load) + int'(shreg_shift) + int'(shreg_clear) <= 1, 1);
            if (post_abort) begin
                check("abort_busy", busy, 0);
                check("abort_serial", serial_out, 0);
                post_abort = 0;
            end
            if (pending > 0) begin
                if (exp_serial.size() == 0) check("serial_exp_avail", exp_serial.size(), 1);
                else check("serial_bit", serial_out, exp_serial.pop_front());
                pending--;
                last_pop = cyc;
            end
            if (underrun) begin
                if (end_q.size() == 0) check("underrun_unexpected", end_q.size(), 1);
                else check("end_kind_ur", 2, end_q.pop_front());
                check("underrun_timing", (pending == 0) && (last_pop == cyc), 1);
            end
            if (frame_done) begin
                if (end_q.size() == 0) check("frame_done_unexpected", end_q.size(), 1);
                else check("end_kind_done", 1, end_q.pop_front());
                check("frame_done_timing", cyc - last_pop, 1);
            end
            if (abort && pending > 0) begin
                check("abort_clear", shreg_clear, 1);
                check("abort_no_load", shreg_load, 0);
                check("abort_no_status", int'(frame_done) + int'(underrun), 0);
                exp_serial.delete();
                pending    = 0;
                post_abort = 1;
            end
            if (shreg_load) pending += DB * CPB;
        end
    end

    task automatic push_bits(input logic [7:0] d);
        for (int b = DB - 1; b >= 0; b--)
            for (int k = 0; k < CPB; k++) exp_serial.push_back(d[b]);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int w = 0; w < 2000 && !idle; w++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        check("idle_timeout", idle, 1);
        @(posedge clk);
        #1;
    endtask

    // sends n bytes from fb; ur leaves the final byte non-last; do_abort aborts byte 0
    task automatic send_frame(input int n, input bit ur, input bit do_abort, input int abort_at,
                              input bit drop_en);
        bit got;
        bit is_last;
        tx_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            is_last = (i == n - 1) && !ur;
            cur_data = fb[i];
            bus.byte_valid = 1'b1;
            bus.byte_last  = is_last;
            got = 0;
            for (int w = 0; w < 100 && !got; w++) begin
                @(negedge clk);
                if (bus.byte_ready) got = 1;
            end
            if (!got) begin
                check("accept_timeout", got, 1);
                bus.byte_valid = 1'b0;
                return;
            end
            @(posedge clk);
            push_bits(fb[i]);
            if ((i == n - 1) && !do_abort) end_q.push_back(ur ? 2 : 1);
            #1;
            if (i == 0 && drop_en) tx_en = 1'b0;
        end
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        if (do_abort) begin
            repeat (abort_at - 1) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
        end
        wait_idle();
        tx_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        cur_data = '0;
        tx_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.byte_ready, 1);
        check("rst_load", shreg_load, 0);
        check("rst_shift", shreg_shift, 0);
        check("rst_clear", shreg_clear, 0);
        check("rst_busy", busy, 0);
        check("rst_status", int'(frame_done) + int'(underrun), 0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;

        fb[0] = 8'hA5;
        send_frame(1, 0, 0, 0, 0);
        fb[0] = 8'h3C; fb[1] = 8'hFF;
        send_frame(2, 0, 0, 0, 0);
        fb[0] = 8'h81;
        send_frame(1, 1, 0, 0, 0);
        fb[0] = 8'hF0;
        send_frame(1, 0, 1, 10, 0);
        fb[0] = 8'h6E;
        send_frame(1, 0, 0, 0, 0);

        // tx_en low holds off acceptance
        tx_en = 1'b0;
        cur_data = 8'hC3;
        bus.byte_valid = 1'b1;
        bus.byte_last  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("txen_low_ready", bus.byte_ready, 0);
            check("txen_low_load", shreg_load, 0);
        end
        @(posedge clk);
        #1 tx_en = 1'b1;
        #1;
        check("txen_rise_ready", bus.byte_ready, 1);
        check("txen_rise_load", shreg_load, 1);
        fb[0] = 8'hC3;
        send_frame(1, 0, 0, 0, 0);

        // asynchronous reset mid-byte
        cur_data = 8'h96;
        bus.byte_valid = 1'b1;
        bus.byte_last  = 1'b1;
        got = 0;
        for (int w = 0; w < 100 && !got; w++) begin
            @(negedge clk);
            if (bus.byte_ready) got = 1;
        end
        check("rst_test_accept", got, 1);
        @(posedge clk);
        push_bits(8'h96);
        end_q.push_back(1);
        #1 bus.byte_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 n_rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_strobes", int'(shreg_load) + int'(shreg_shift) + int'(shreg_clear), 0);
        check("arst_ready", bus.byte_ready, 1);
        check("arst_status", int'(frame_done) + int'(underrun), 0);
        check("arst_serial", serial_out, 0);
        exp_serial.delete();
        end_q.delete();
        @(posedge clk);
        #1 n_rst = 1'b1;
        fb[0] = 8'h55;
        send_frame(1, 0, 0, 0, 0);

        // randomized frames
        for (int it = 0; it < 14; it++) begin
            int kind;
            int n;
            kind = int'($urandom_range(0, 4));
            n = int'($urandom_range(1, 3));
            for (int j = 0; j < 4; j++) fb[j] = 8'($urandom);
            if (kind == 0)      send_frame(1, 0, 1, int'($urandom_range(1, 30)), 0);
            else if (kind == 1) send_frame(n, 1, 0, 0, 1'($urandom));
            else                send_frame(n, 0, 0, 0, 1'($urandom));
        end

        check("serial_left", exp_serial.size(), 0);
        check("end_left", end_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
